// File: rtl/usb_fx2_slave_fifo_responder.sv
// Chip-side stand-in for the FX2 slave-FIFO bus: EP2 OUT FIFO filled from a host port
// and read over usb_fd, EP6 IN FIFO written over usb_fd and drained by a host port.
module usb_fx2_slave_fifo_responder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [1:0]        usb_fifoaddr,
  input  logic              usb_slcs,
  input  logic              usb_sloe,
  input  logic              usb_slrd,
  input  logic              usb_slwr,
  inout  wire  [15:0]       usb_fd,
  output logic              usb_flaga,
  output logic              usb_flagb,
  output logic              usb_flagc,
  input  logic              host_wr_en,
  input  logic [15:0]       host_wr_data,
  output logic              host_wr_full,
  output logic              host_rd_valid,
  output logic [15:0]       host_rd_data,
  input  logic              host_rd_ready,
  output logic [ADDR_W:0]   ep2_count,
  output logic [ADDR_W:0]   ep6_count,
  output logic              err_underrun,
  output logic              err_overrun
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  // Pin capture: s1 is the first register stage, s0 the previous s1 value
  logic              slcs_s1_q, sloe_s1_q, slrd_s1_q, slwr_s1_q;
  logic [1:0]        addr_s1_q;
  logic [15:0]       fd_s1_q;
  logic              slrd_s0_q, slwr_s0_q;
  logic [15:0]       fd_s0_q;

  logic              fd_oe_q;
  logic              flaga_q, flagc_q;
  logic              underrun_q, overrun_q;

  logic [15:0]       ep2_mem_q [DEPTH];
  logic [ADDR_W-1:0] ep2_wr_q, ep2_wr_d, ep2_rd_q, ep2_rd_d;
  logic [ADDR_W:0]   ep2_cnt_q, ep2_cnt_d;
  logic [15:0]       ep2_head_q, ep2_head_d;

  logic [15:0]       ep6_mem_q [DEPTH];
  logic [ADDR_W-1:0] ep6_wr_q, ep6_wr_d, ep6_rd_q, ep6_rd_d;
  logic [ADDR_W:0]   ep6_cnt_q, ep6_cnt_d;

  logic sel, rd_rise, wr_rise;
  logic ep2_push, ep2_pop, ep6_push, ep6_pop;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      slcs_s1_q <= 1'b1;
      sloe_s1_q <= 1'b1;
      slrd_s1_q <= 1'b1;
      slwr_s1_q <= 1'b1;
      addr_s1_q <= 2'b00;
      fd_s1_q   <= '0;
      slrd_s0_q <= 1'b1;
      slwr_s0_q <= 1'b1;
      fd_s0_q   <= '0;
    end else begin
      slcs_s1_q <= usb_slcs;
      sloe_s1_q <= usb_sloe;
      slrd_s1_q <= usb_slrd;
      slwr_s1_q <= usb_slwr;
      addr_s1_q <= usb_fifoaddr;
      fd_s1_q   <= usb_fd;
      slrd_s0_q <= slrd_s1_q;
      slwr_s0_q <= slwr_s1_q;
      fd_s0_q   <= fd_s1_q;
    end
  end

  assign sel      = ~slcs_s1_q;
  assign rd_rise  = sel && (addr_s1_q == 2'b00) && !slrd_s0_q && slrd_s1_q;
  assign wr_rise  = sel && (addr_s1_q == 2'b10) && !slwr_s0_q && slwr_s1_q;

  assign ep2_push = host_wr_en && (ep2_cnt_q != CNT_FULL);
  assign ep2_pop  = rd_rise && (ep2_cnt_q != '0);
  assign ep6_push = wr_rise && (ep6_cnt_q != CNT_FULL);
  assign ep6_pop  = host_rd_valid && host_rd_ready;

  always_comb begin
    ep2_wr_d  = ep2_push ? ep2_wr_q + 1'b1 : ep2_wr_q;
    ep2_rd_d  = ep2_pop  ? ep2_rd_q + 1'b1 : ep2_rd_q;
    ep2_cnt_d = ep2_cnt_q;
    if (ep2_push && !ep2_pop)
      ep2_cnt_d = ep2_cnt_q + 1'b1;
    else if (!ep2_push && ep2_pop)
      ep2_cnt_d = ep2_cnt_q - 1'b1;
    // A word written this cycle becomes the head when it lands where rd_ptr will point
    if (ep2_cnt_d == '0)
      ep2_head_d = '0;
    else if (ep2_push && (ep2_rd_d == ep2_wr_q))
      ep2_head_d = host_wr_data;
    else
      ep2_head_d = ep2_mem_q[ep2_rd_d];
  end

  always_comb begin
    ep6_wr_d  = ep6_push ? ep6_wr_q + 1'b1 : ep6_wr_q;
    ep6_rd_d  = ep6_pop  ? ep6_rd_q + 1'b1 : ep6_rd_q;
    ep6_cnt_d = ep6_cnt_q;
    if (ep6_push && !ep6_pop)
      ep6_cnt_d = ep6_cnt_q + 1'b1;
    else if (!ep6_push && ep6_pop)
      ep6_cnt_d = ep6_cnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ep2_wr_q   <= '0;
      ep2_rd_q   <= '0;
      ep2_cnt_q  <= '0;
      ep2_head_q <= '0;
      ep6_wr_q   <= '0;
      ep6_rd_q   <= '0;
      ep6_cnt_q  <= '0;
      fd_oe_q    <= 1'b0;
      flaga_q    <= 1'b0;
      flagc_q    <= 1'b1;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      ep2_wr_q   <= ep2_wr_d;
      ep2_rd_q   <= ep2_rd_d;
      ep2_cnt_q  <= ep2_cnt_d;
      ep2_head_q <= ep2_head_d;
      ep6_wr_q   <= ep6_wr_d;
      ep6_rd_q   <= ep6_rd_d;
      ep6_cnt_q  <= ep6_cnt_d;
      fd_oe_q    <= sel && !sloe_s1_q && (addr_s1_q == 2'b00);
      flaga_q    <= (ep2_cnt_d != '0);
      flagc_q    <= (ep6_cnt_d != CNT_FULL);
      if (rd_rise && (ep2_cnt_q == '0))
        underrun_q <= 1'b1;
      if (wr_rise && (ep6_cnt_q == CNT_FULL))
        overrun_q <= 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked purely by the counts
  always_ff @(posedge sys_clk) begin
    if (ep2_push)
      ep2_mem_q[ep2_wr_q] <= host_wr_data;
    if (ep6_push)
      ep6_mem_q[ep6_wr_q] <= fd_s0_q;
  end

  assign usb_fd        = fd_oe_q ? ep2_head_q : 16'hzzzz;
  assign usb_flaga     = flaga_q;
  assign usb_flagb     = 1'b0;
  assign usb_flagc     = flagc_q;
  assign host_wr_full  = (ep2_cnt_q == CNT_FULL);
  assign host_rd_valid = (ep6_cnt_q != '0);
  assign host_rd_data  = host_rd_valid ? ep6_mem_q[ep6_rd_q] : 16'h0000;
  assign ep2_count     = ep2_cnt_q;
  assign ep6_count     = ep6_cnt_q;
  assign err_underrun  = underrun_q;
  assign err_overrun   = overrun_q;

endmodule
